// File: rtl/rll_key_loader_if.sv
// Serial key-load bus between the secure key store and the RLL key loader.
// Handshake: a key bit transfers on a rising clk edge where bit_valid and bit_ready are both 1.
interface rll_key_loader_if #(
    parameter int KEY_W = 16
) ();
    logic             load_req;
    logic             zeroize;
    logic             bit_valid;
    logic             key_bit;
    logic             bit_ready;
    logic             busy;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             load_err;

    modport master (
        output load_req, zeroize, bit_valid, key_bit,
        input  bit_ready, busy, key_out, key_valid, load_err
    );

    modport slave (
        input  load_req, zeroize, bit_valid, key_bit,
        output bit_ready, busy, key_out, key_valid, load_err
    );
endinterface

// File: rtl/rll_key_loader.sv
// Loads the logic-locking key serially (MSB first) into a shadow register, optionally checks
// even parity, and commits it to key_out in one step so the locked core never sees a partial key.
module rll_key_loader #(
    parameter int KEY_W     = 16,
    parameter bit PARITY_EN = 1'b1,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst,
    rll_key_loader_if.slave     bus,
    output logic [2:0]          dbg_state
);
    localparam int CW = $clog2(KEY_W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(KEY_W - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        PARITY = 3'd2,
        COMMIT = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [KEY_W-1:0] shadow;
    logic [CW-1:0]    bit_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic             accept;
    logic             tmo_hit;
    logic             par_bad;

    assign accept    = bus.bit_valid & bus.bit_ready;
    assign tmo_hit   = (tmo_cnt == TMO_MAX);
    assign par_bad   = (^shadow) ^ bus.key_bit;
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.load_req) state_nx = SHIFT;
            end
            SHIFT: begin
                if (accept) begin
                    if (bit_cnt == LAST_BIT) state_nx = PARITY_EN ? PARITY : COMMIT;
                end else if (tmo_hit) begin
                    state_nx = ERR;
                end
            end
            PARITY: begin
                if (accept)       state_nx = par_bad ? ERR : COMMIT;
                else if (tmo_hit) state_nx = ERR;
            end
            COMMIT:  state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.zeroize) state_nx = IDLE;
    end

    // bit_ready/busy are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shadow        <= '0;
            bit_cnt       <= '0;
            tmo_cnt       <= '0;
            bus.key_out   <= '0;
            bus.key_valid <= 1'b0;
            bus.load_err  <= 1'b0;
            bus.bit_ready <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.bit_ready <= (state_nx == SHIFT) || (state_nx == PARITY);
            bus.busy      <= (state_nx != IDLE);
            if (bus.zeroize) begin
                shadow        <= '0;
                bit_cnt       <= '0;
                tmo_cnt       <= '0;
                bus.key_out   <= '0;
                bus.key_valid <= 1'b0;
                bus.load_err  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.load_req) begin
                            shadow        <= '0;
                            bit_cnt       <= '0;
                            tmo_cnt       <= '0;
                            bus.key_valid <= 1'b0;
                            bus.load_err  <= 1'b0;
                        end
                    end
                    SHIFT, PARITY: begin
                        if (accept) begin
                            if (state == SHIFT) begin
                                shadow  <= {shadow[KEY_W-2:0], bus.key_bit};
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                            tmo_cnt <= '0;
                        end else if (!tmo_hit) begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    COMMIT: begin
                        bus.key_out   <= shadow;
                        bus.key_valid <= 1'b1;
                    end
                    ERR: begin
                        bus.key_out   <= '0;
                        bus.key_valid <= 1'b0;
                        shadow        <= '0;
                        bus.load_err  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader: table of parity loads plus hand sequences for reset,
// timeout, busy/zeroize and a no-parity instance with irregular bit_valid.
module tb_rll_key_loader;
    localparam int KEY_W = 16;
    localparam int TMO   = 20;

    typedef struct {
        logic [15:0] key;
        logic        par;
        logic [15:0] exp_key;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] dbg_p, dbg_n;
    int errors = 0;
    int checks = 0;
    logic [KEY_W-1:0] exp_q[$];
    logic [15:0] prev_key;
    vec_t vecs[6];

    rll_key_loader_if #(.KEY_W(KEY_W)) bus_p ();
    rll_key_loader_if #(.KEY_W(KEY_W)) bus_n ();

    rll_key_loader #(.KEY_W(KEY_W), .PARITY_EN(1'b1), .TIMEOUT(TMO)) dut_p (
        .clk(clk), .rst(rst), .bus(bus_p), .dbg_state(dbg_p)
    );
    rll_key_loader #(.KEY_W(KEY_W), .PARITY_EN(1'b0), .TIMEOUT(TMO)) dut_n (
        .clk(clk), .rst(rst), .bus(bus_n), .dbg_state(dbg_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full load on the parity instance; a gap of idle cycles may follow the 9th bit.
    task automatic load_p(input logic [15:0] key, input logic par, input int gap);
        bus_p.load_req = 1'b1;
        step();
        bus_p.load_req = 1'b0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            bus_p.bit_valid = 1'b1;
            bus_p.key_bit   = key[i];
            step();
            if ((KEY_W - i) == 9 && gap > 0) begin
                bus_p.bit_valid = 1'b0;
                repeat (gap) step();
            end
        end
        bus_p.bit_valid = 1'b1;
        bus_p.key_bit   = par;
        step();
        bus_p.bit_valid = 1'b0;
    endtask

    initial begin
        bus_p.load_req = 0; bus_p.zeroize = 0; bus_p.bit_valid = 0; bus_p.key_bit = 0;
        bus_n.load_req = 0; bus_n.zeroize = 0; bus_n.bit_valid = 0; bus_n.key_bit = 0;
        vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 1'b1, 1'b0};
        vecs[1] = '{16'hA5C3, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 1'b1, 16'h1234, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h8001, 1'b0, 16'h8001, 1'b1, 1'b0};

        repeat (2) step();
        chk("rst_key_out", 32'(bus_p.key_out), 0);
        chk("rst_key_valid", 32'(bus_p.key_valid), 0);
        chk("rst_load_err", 32'(bus_p.load_err), 0);
        chk("rst_busy", 32'(bus_p.busy), 0);
        chk("rst_bit_ready", 32'(bus_p.bit_ready), 0);
        chk("rst_n_key_out", 32'(bus_n.key_out), 0);
        #3 rst = 1'b0;
        step();

        // Table: parity loads, good and bad.
        prev_key = 16'h0000;
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v].exp_key);
            load_p(vecs[v].key, vecs[v].par, 0);
            chk($sformatf("v%0d_hold_key", v), 32'(bus_p.key_out), 32'(prev_key));
            chk($sformatf("v%0d_pre_valid", v), 32'(bus_p.key_valid), 0);
            step();
            chk($sformatf("v%0d_key_out", v), 32'(bus_p.key_out), 32'(exp_q.pop_front()));
            chk($sformatf("v%0d_key_valid", v), 32'(bus_p.key_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("v%0d_load_err", v), 32'(bus_p.load_err), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_busy", v), 32'(bus_p.busy), 0);
            prev_key = vecs[v].exp_key;
        end

        // Timeout: long gap after bit 9 aborts; the remaining bits land in IDLE and are ignored.
        load_p(16'hA5C3, 1'b0, TMO + 3);
        step();
        chk("tmo_load_err", 32'(bus_p.load_err), 1);
        chk("tmo_key_out", 32'(bus_p.key_out), 0);
        chk("tmo_key_valid", 32'(bus_p.key_valid), 0);
        chk("tmo_busy", 32'(bus_p.busy), 0);
        load_p(16'hA5C3, 1'b0, TMO - 1);
        step();
        chk("gap_ok_key_out", 32'(bus_p.key_out), 32'h0000_A5C3);
        chk("gap_ok_key_valid", 32'(bus_p.key_valid), 1);
        chk("gap_ok_load_err", 32'(bus_p.load_err), 0);

        // Commit 0x1234, then a partial load with a stray load_req, then zeroize.
        load_p(16'h1234, 1'b1, 0);
        step();
        chk("c1234_key_out", 32'(bus_p.key_out), 32'h0000_1234);
        bus_p.load_req = 1'b1;
        step();
        bus_p.load_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_p.bit_valid = 1'b1;
            bus_p.key_bit   = i[0];
            bus_p.load_req  = (i == 3);
            step();
        end
        bus_p.load_req  = 1'b0;
        bus_p.bit_valid = 1'b0;
        chk("mid_key_out", 32'(bus_p.key_out), 32'h0000_1234);
        chk("mid_key_valid", 32'(bus_p.key_valid), 0);
        chk("mid_busy", 32'(bus_p.busy), 1);
        chk("mid_state", 32'(dbg_p), 1);
        bus_p.zeroize   = 1'b1;
        bus_p.bit_valid = 1'b1;
        step();
        bus_p.zeroize   = 1'b0;
        bus_p.bit_valid = 1'b0;
        chk("zer_key_out", 32'(bus_p.key_out), 0);
        chk("zer_busy", 32'(bus_p.busy), 0);
        chk("zer_bit_ready", 32'(bus_p.bit_ready), 0);
        chk("zer_state", 32'(dbg_p), 0);

        // Zeroize in the COMMIT cycle wins over the commit.
        load_p(16'hFFFF, 1'b0, 0);
        bus_p.zeroize = 1'b1;
        step();
        bus_p.zeroize = 1'b0;
        chk("zc_key_out", 32'(bus_p.key_out), 0);
        chk("zc_key_valid", 32'(bus_p.key_valid), 0);

        // Async reset in the middle of SHIFT, with a committed key present.
        load_p(16'h8001, 1'b0, 0);
        step();
        chk("pre_rst_key_out", 32'(bus_p.key_out), 32'h0000_8001);
        bus_p.load_req = 1'b1;
        step();
        bus_p.load_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus_p.bit_valid = 1'b1;
            bus_p.key_bit   = 1'b1;
            step();
        end
        bus_p.bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_key_out", 32'(bus_p.key_out), 0);
        chk("arst_key_valid", 32'(bus_p.key_valid), 0);
        chk("arst_busy", 32'(bus_p.busy), 0);
        chk("arst_bit_ready", 32'(bus_p.bit_ready), 0);
        #1 rst = 1'b0;
        step();

        // No-parity instance with irregular bit_valid; bits offered in IDLE/COMMIT are dropped.
        for (int r = 0; r < 3; r++) begin
            logic [15:0] exp_key;
            int n;
            int gap;
            logic v;
            logic b;
            exp_key = '0;
            n = 0;
            gap = 0;
            bus_n.load_req  = 1'b1;
            bus_n.bit_valid = 1'b1;
            bus_n.key_bit   = 1'b1;
            step();
            bus_n.load_req = 1'b0;
            while (n < KEY_W) begin
                v = 1'($urandom_range(0, 1));
                if (gap >= 4) v = 1'b1;
                b = 1'($urandom_range(0, 1));
                bus_n.bit_valid = v;
                bus_n.key_bit   = b;
                if (v) begin
                    exp_key = {exp_key[14:0], b};
                    n++;
                    gap = 0;
                end else begin
                    gap++;
                end
                step();
            end
            bus_n.bit_valid = 1'b1;
            bus_n.key_bit   = ~exp_key[0];
            step();
            chk($sformatf("np%0d_key_out", r), 32'(bus_n.key_out), 32'(exp_key));
            chk($sformatf("np%0d_key_valid", r), 32'(bus_n.key_valid), 1);
            chk($sformatf("np%0d_load_err", r), 32'(bus_n.load_err), 0);
            repeat (2) step();
            bus_n.bit_valid = 1'b0;
            chk($sformatf("np%0d_idle_key", r), 32'(bus_n.key_out), 32'(exp_key));
            chk($sformatf("np%0d_idle_busy", r), 32'(bus_n.busy), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
